sc_lifelevel_tracker: RTL and testbench



---
 rtl/sc_lifelevel_tracker_if.sv | 34 +++
 rtl/sc_lifelevel_tracker.sv | 106 ++++++++++
 tb/tb_sc_lifelevel_tracker.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sc_lifelevel_tracker_if.sv
// Strobe/status bundle between the Frogger game FSM (master) and the lives/level tracker (slave).
// Signal names follow the legacy top-level port names so existing netlists map one-to-one.
interface sc_lifelevel_tracker_if;
    logic       SC_LIFELEVELTRACKER_StartGame_InLow;
    logic       SC_LIFELEVELTRACKER_LoseLife_InLow;
    logic       SC_LIFELEVELTRACKER_NextLevel_InLow;
    logic       SC_LIFELEVELTRACKER_LifesCounterComparator_OutLow;
    logic       SC_LIFELEVELTRACKER_LevelCounterComparator_OutLow;
    logic       SC_LIFELEVELTRACKER_Hold_OutLow;
    logic [2:0] SC_LIFELEVELTRACKER_Lives_OutBUS;
    logic [2:0] SC_LIFELEVELTRACKER_Level_OutBUS;

    modport master (
        output SC_LIFELEVELTRACKER_StartGame_InLow,
        output SC_LIFELEVELTRACKER_LoseLife_InLow,
        output SC_LIFELEVELTRACKER_NextLevel_InLow,
        input  SC_LIFELEVELTRACKER_LifesCounterComparator_OutLow,
        input  SC_LIFELEVELTRACKER_LevelCounterComparator_OutLow,
        input  SC_LIFELEVELTRACKER_Hold_OutLow,
        input  SC_LIFELEVELTRACKER_Lives_OutBUS,
        input  SC_LIFELEVELTRACKER_Level_OutBUS
    );

    modport slave (
        input  SC_LIFELEVELTRACKER_StartGame_InLow,
        input  SC_LIFELEVELTRACKER_LoseLife_InLow,
        input  SC_LIFELEVELTRACKER_NextLevel_InLow,
        output SC_LIFELEVELTRACKER_LifesCounterComparator_OutLow,
        output SC_LIFELEVELTRACKER_LevelCounterComparator_OutLow,
        output SC_LIFELEVELTRACKER_Hold_OutLow,
        output SC_LIFELEVELTRACKER_Lives_OutBUS,
        output SC_LIFELEVELTRACKER_Level_OutBUS
    );
endinterface

// File: rtl/sc_lifelevel_tracker.sv
// Lives/level bookkeeping with a post-event hold window for the Frogger game FSM.
// Optional feature: define SC_LIFELEVELTRACKER_BONUSLIFE_EN to award a life on each non-final level advance.
module sc_lifelevel_tracker #(
    parameter int unsigned LIVES_INIT = 3,
    parameter int unsigned LIVES_MAX  = 7,
    parameter int unsigned LEVEL_MAX  = 5,
    parameter int unsigned HOLD_TICKS = 25000000,
    parameter int unsigned HOLD_WIDTH = 25
) (
    input  logic                         SC_LIFELEVELTRACKER_CLOCK_50,
    input  logic                         SC_LIFELEVELTRACKER_RESET_InHigh,
    sc_lifelevel_tracker_if.slave        bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    // Initial lives are clamped to the ceiling so a mis-set LIVES_INIT cannot exceed it.
    localparam logic [2:0] LIVES_LOAD = (LIVES_INIT > LIVES_MAX) ? 3'(LIVES_MAX) : 3'(LIVES_INIT);
    localparam logic [2:0] LIVES_TOP  = 3'(LIVES_MAX);
    localparam logic [2:0] LEVEL_TOP  = 3'(LEVEL_MAX);
    localparam logic [HOLD_WIDTH-1:0] HOLD_LOAD = HOLD_WIDTH'(HOLD_TICKS - 1);

    logic [1:0]            state;
    logic [2:0]            lives;
    logic [2:0]            level;
    logic [HOLD_WIDTH-1:0] timer;

    logic       start;
    logic       lose;
    logic       next;
    logic [2:0] lives_dec;
    logic [2:0] level_inc;
    logic [2:0] lives_bonus;

    assign start = ~bus.SC_LIFELEVELTRACKER_StartGame_InLow;
    assign lose  = ~bus.SC_LIFELEVELTRACKER_LoseLife_InLow;
    assign next  = ~bus.SC_LIFELEVELTRACKER_NextLevel_InLow;

    assign lives_dec = (lives == '0) ? '0 : lives - 3'd1;
    assign level_inc = (level >= LEVEL_TOP) ? LEVEL_TOP : level + 3'd1;

`ifdef SC_LIFELEVELTRACKER_BONUSLIFE_EN
    assign lives_bonus = (level_inc == LEVEL_TOP) ? lives :
                         ((lives >= LIVES_TOP) ? LIVES_TOP : lives + 3'd1);
`else
    assign lives_bonus = lives;
`endif

    always_ff @(posedge SC_LIFELEVELTRACKER_CLOCK_50) begin
        if (SC_LIFELEVELTRACKER_RESET_InHigh) begin
            state <= ST_IDLE;
            lives <= LIVES_LOAD;
            level <= '0;
            timer <= '0;
        end else if (start) begin
            state <= ST_PLAY;
            lives <= LIVES_LOAD;
            level <= '0;
            timer <= '0;
        end else begin
            case (state)
                ST_PLAY: begin
                    if (lose) begin
                        lives <= lives_dec;
                        if (lives_dec == '0) begin
                            state <= ST_OVER;
                        end else begin
                            timer <= HOLD_LOAD;
                            state <= ST_HOLD;
                        end
                    end else if (next) begin
                        level <= level_inc;
                        lives <= lives_bonus;
                        if (level_inc == LEVEL_TOP) begin
                            state <= ST_OVER;
                        end else begin
                            timer <= HOLD_LOAD;
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (timer == '0) begin
                        state <= ST_PLAY;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    // IDLE and OVER hold everything until StartGame or reset.
                    state <= state;
                end
            endcase
        end
    end

    assign bus.SC_LIFELEVELTRACKER_LifesCounterComparator_OutLow = (lives != '0);
    assign bus.SC_LIFELEVELTRACKER_LevelCounterComparator_OutLow = (level != LEVEL_TOP);
    assign bus.SC_LIFELEVELTRACKER_Hold_OutLow                   = (state != ST_HOLD);
    assign bus.SC_LIFELEVELTRACKER_Lives_OutBUS                  = lives;
    assign bus.SC_LIFELEVELTRACKER_Level_OutBUS                  = level;

endmodule

// File: tb/tb_sc_lifelevel_tracker.sv
// Self-checking bench for sc_lifelevel_tracker: directed vector table, level-up sequence, random run vs model.
module tb_sc_lifelevel_tracker;

    localparam int HT  = 4;
    localparam int LI  = 3;
    localparam int LM  = 7;
    localparam int LVM = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sc_lifelevel_tracker_if bus ();

    sc_lifelevel_tracker #(
        .LIVES_INIT (LI),
        .LIVES_MAX  (LM),
        .LEVEL_MAX  (LVM),
        .HOLD_TICKS (HT),
        .HOLD_WIDTH (3)
    ) dut (
        .SC_LIFELEVELTRACKER_CLOCK_50     (clk),
        .SC_LIFELEVELTRACKER_RESET_InHigh (rst),
        .bus                              (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 = not started, 1 = game running, 2 = game over;
    // hold_left counts the remaining cycles during which strobes are ignored.
    int m_lives;
    int m_level;
    int m_mode;
    int m_hold_left;

    task automatic model_step(input bit r, input bit s, input bit l, input bit n);
        if (r) begin
            m_lives = LI; m_level = 0; m_mode = 0; m_hold_left = 0;
        end else if (s) begin
            m_lives = LI; m_level = 0; m_mode = 1; m_hold_left = 0;
        end else if (m_mode == 1) begin
            if (m_hold_left > 0) begin
                m_hold_left = m_hold_left - 1;
            end else if (l) begin
                m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                if (m_lives == 0) m_mode = 2;
                else m_hold_left = HT;
            end else if (n) begin
                m_level = (m_level < LVM) ? m_level + 1 : LVM;
`ifdef SC_LIFELEVELTRACKER_BONUSLIFE_EN
                if (m_level != LVM) m_lives = (m_lives < LM) ? m_lives + 1 : LM;
`endif
                if (m_level == LVM) m_mode = 2;
                else m_hold_left = HT;
            end
        end
    endtask

    task automatic tick(input bit r, input bit s, input bit l, input bit n);
        @(negedge clk);
        rst = r;
        bus.SC_LIFELEVELTRACKER_StartGame_InLow = ~s;
        bus.SC_LIFELEVELTRACKER_LoseLife_InLow  = ~l;
        bus.SC_LIFELEVELTRACKER_NextLevel_InLow = ~n;
        model_step(r, s, l, n);
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string name, input int lives, input int level,
                           input bit lc, input bit vc, input bit hold);
        int a_lives;
        int a_level;
        a_lives = int'(bus.SC_LIFELEVELTRACKER_Lives_OutBUS);
        a_level = int'(bus.SC_LIFELEVELTRACKER_Level_OutBUS);
        checks = checks + 1;
        if (a_lives !== lives || a_level !== level ||
            bus.SC_LIFELEVELTRACKER_LifesCounterComparator_OutLow !== lc ||
            bus.SC_LIFELEVELTRACKER_LevelCounterComparator_OutLow !== vc ||
            bus.SC_LIFELEVELTRACKER_Hold_OutLow !== hold) begin
            errors = errors + 1;
            $display("FAIL %s @%0t: got lives=%0d level=%0d lc=%b vc=%b hold=%b, expected lives=%0d level=%0d lc=%b vc=%b hold=%b",
                     name, $time, a_lives, a_level,
                     bus.SC_LIFELEVELTRACKER_LifesCounterComparator_OutLow,
                     bus.SC_LIFELEVELTRACKER_LevelCounterComparator_OutLow,
                     bus.SC_LIFELEVELTRACKER_Hold_OutLow,
                     lives, level, lc, vc, hold);
        end
    endtask

    task automatic compare_model(input string name);
        compare(name, m_lives, m_level, m_lives != 0, m_level != LVM, m_hold_left == 0);
    endtask

    typedef struct {
        bit    r;
        bit    s;
        bit    l;
        bit    n;
        int    lives;
        int    level;
        bit    lc;
        bit    vc;
        bit    hold;
        string name;
    } vec_t;

    vec_t vecs[19];

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.SC_LIFELEVELTRACKER_StartGame_InLow = 1'b1;
        bus.SC_LIFELEVELTRACKER_LoseLife_InLow  = 1'b1;
        bus.SC_LIFELEVELTRACKER_NextLevel_InLow = 1'b1;
        m_lives = LI; m_level = 0; m_mode = 0; m_hold_left = 0;

        // Strobe flags are 1 = asserted; expected outputs are raw (active-low) levels.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 0, 1'b1, 1'b1, 1'b1, "reset"};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3, 0, 1'b1, 1'b1, 1'b1, "idle_lose_ignored"};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 0, 1'b1, 1'b1, 1'b1, "start"};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 0, 1'b1, 1'b1, 1'b0, "lose_hold1"};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 0, 1'b1, 1'b1, 1'b0, "lose_in_hold_ignored"};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 1'b1, 1'b1, 1'b0, "hold3"};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 1'b1, 1'b1, 1'b0, "hold4"};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 1'b1, 1'b1, 1'b1, "hold_end"};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 1'b1, 1'b1, 1'b0, "lose_beats_next"};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1, 1'b1, 1'b0, "hold_b2"};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1, 1'b1, 1'b0, "hold_b3"};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1, 1'b1, 1'b0, "hold_b4"};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1, 1'b1, 1'b1, "hold_b_end"};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, "last_life_over"};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 1'b1, "over_strobes_ignored"};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 3, 0, 1'b1, 1'b1, 1'b1, "start_beats_lose"};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 0, 1'b1, 1'b1, 1'b0, "lose_again"};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 0, 1'b1, 1'b1, 1'b1, "reset_in_hold"};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 3, 0, 1'b1, 1'b1, 1'b1, "idle_lose_after_reset"};

        for (int i = 0; i < 19; i++) begin
            tick(vecs[i].r, vecs[i].s, vecs[i].l, vecs[i].n);
            compare(vecs[i].name, vecs[i].lives, vecs[i].level, vecs[i].lc, vecs[i].vc, vecs[i].hold);
        end

        // Level-up to the win level with spaced NextLevel pulses.
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            compare_model("next_level");
            if (k < 2) begin
                for (int w = 0; w < HT; w++) tick(1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
`ifdef SC_LIFELEVELTRACKER_BONUSLIFE_EN
        compare("level_max_reached", 5, 3, 1'b1, 1'b0, 1'b1);
`else
        compare("level_max_reached", 3, 3, 1'b1, 1'b0, 1'b1);
`endif
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        compare_model("over_next_ignored");

        // Strobe held low across a whole hold window acts again right after it.
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < HT + 2; k++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0);
            compare_model("held_lose");
        end
        compare("held_lose_twice", 1, 0, 1'b1, 1'b1, 1'b0);

        // Randomized run against the reference model.
        for (int c = 0; c < 3000; c++) begin
            bit r;
            bit s;
            bit l;
            bit n;
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 39) == 0);
            l = ($urandom_range(0, 3) == 0);
            n = ($urandom_range(0, 2) == 0);
            tick(r, s, l, n);
            compare_model("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
